// File: rtl/vlsu_axi_ot_tracker.sv
// -----------------------------------------------------------------------------
// vlsu_axi_ot_tracker
//
// Purpose:
//   Sits between the vector load/store unit's AXI master port and the memory
//   interconnect. All five channels pass through with zero added latency. The
//   block only sees handshakes, last bits and response codes; payload buses
//   are routed around it. It caps and counts outstanding read (AR without its
//   R last) and write (AW without its B) bursts, reports "stores in flight"
//   and idle status, and keeps sticky response/protocol error flags.
//
// Optional feature (macro VLSU_AXI_OT_W_GATE_EN):
//   When defined, W beats are held back until their AW has been accepted, and
//   AW acceptance is limited to MaxWPend bursts whose W last is still owed.
//   When undefined, W passes through untouched and no W tracking state exists.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   s_aw_*/m_aw_*                 AW handshake, gated when write cap reached
//   s_w_*/m_w_*                   W handshake (+ last), optionally gated
//   m_b_*/s_b_*                   B handshake + resp, pass-through
//   s_ar_*/m_ar_*                 AR handshake, gated when read cap reached
//   m_r_*/s_r_*                   R handshake + last + resp, pass-through
//   clr_err_i                     clears sticky error flags
//   rd_ot_o, wr_ot_o              outstanding read / write burst counts
//   st_pending_o                  writes outstanding
//   idle_o                        nothing outstanding
//   resp_err_o                    sticky: SLVERR/DECERR seen on B or R
//   proto_err_o                   sticky: B / R last with its counter at zero
// -----------------------------------------------------------------------------
module vlsu_axi_ot_tracker #(
   parameter int MaxRdOt  = 8,
   parameter int MaxWrOt  = 8,
   parameter int MaxWPend = 4,
   parameter int CntW     = $clog2(((MaxRdOt > MaxWrOt) ? MaxRdOt : MaxWrOt) + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   // AW
   input  logic            s_aw_valid_i,
   output logic            s_aw_ready_o,
   output logic            m_aw_valid_o,
   input  logic            m_aw_ready_i,
   // W
   input  logic            s_w_valid_i,
   input  logic            s_w_last_i,
   output logic            s_w_ready_o,
   output logic            m_w_valid_o,
   input  logic            m_w_ready_i,
   // B
   input  logic            m_b_valid_i,
   input  logic [1:0]      m_b_resp_i,
   output logic            m_b_ready_o,
   output logic            s_b_valid_o,
   input  logic            s_b_ready_i,
   // AR
   input  logic            s_ar_valid_i,
   output logic            s_ar_ready_o,
   output logic            m_ar_valid_o,
   input  logic            m_ar_ready_i,
   // R
   input  logic            m_r_valid_i,
   input  logic            m_r_last_i,
   input  logic [1:0]      m_r_resp_i,
   output logic            m_r_ready_o,
   output logic            s_r_valid_o,
   input  logic            s_r_ready_i,
   // status
   input  logic            clr_err_i,
   output logic [CntW-1:0] rd_ot_o,
   output logic [CntW-1:0] wr_ot_o,
   output logic            st_pending_o,
   output logic            idle_o,
   output logic            resp_err_o,
   output logic            proto_err_o
);

   localparam logic [CntW-1:0] RdMax   = CntW'(MaxRdOt);
   localparam logic [CntW-1:0] WrMax   = CntW'(MaxWrOt);
   localparam logic [CntW-1:0] CntZero = {CntW{1'b0}};

   // Counter step: +1/-1 cancel; a lone decrement at zero saturates at zero.
   function automatic logic [CntW-1:0] next_cnt(input logic [CntW-1:0] cnt,
                                                input logic            inc,
                                                input logic            dec);
      logic [CntW-1:0] nxt;
      case ({inc, dec})
         2'b10:   nxt = cnt + CntW'(1'b1);
         2'b01:   nxt = (cnt == CntZero) ? cnt : (cnt - CntW'(1'b1));
         default: nxt = cnt;
      endcase
      return nxt;
   endfunction

   // Error-class response (SLVERR or DECERR).
   function automatic logic is_err_resp(input logic [1:0] resp);
      return (resp == 2'b10) || (resp == 2'b11);
   endfunction

   logic [CntW-1:0] rd_cnt_r, rd_cnt_d_s;
   logic [CntW-1:0] wr_cnt_r, wr_cnt_d_s;
   logic            resp_err_r, proto_err_r;
   logic            resp_err_d_s, proto_err_d_s;

   logic rd_full_s, wr_full_s, w_pend_full_s;
   logic ar_hs_s, aw_hs_s, r_last_hs_s, b_hs_s;
   logic resp_set_s, proto_set_s;

   // Gating decodes come only from registered state, so valid never waits on ready.
   assign rd_full_s = (rd_cnt_r == RdMax);
   assign wr_full_s = (wr_cnt_r == WrMax);

   assign m_ar_valid_o = s_ar_valid_i & ~rd_full_s;
   assign s_ar_ready_o = m_ar_ready_i & ~rd_full_s;
   assign m_aw_valid_o = s_aw_valid_i & ~wr_full_s & ~w_pend_full_s;
   assign s_aw_ready_o = m_aw_ready_i & ~wr_full_s & ~w_pend_full_s;

   assign s_r_valid_o = m_r_valid_i;
   assign m_r_ready_o = s_r_ready_i;
   assign s_b_valid_o = m_b_valid_i;
   assign m_b_ready_o = s_b_ready_i;

   assign ar_hs_s     = m_ar_valid_o & m_ar_ready_i;
   assign aw_hs_s     = m_aw_valid_o & m_aw_ready_i;
   assign r_last_hs_s = m_r_valid_i & s_r_ready_i & m_r_last_i;
   assign b_hs_s      = m_b_valid_i & s_b_ready_i;

   // Response errors count on every R beat, not only the last one.
   assign resp_set_s  = (m_r_valid_i & s_r_ready_i & is_err_resp(m_r_resp_i)) |
                        (b_hs_s & is_err_resp(m_b_resp_i));
   // A completion with nothing outstanding is a protocol error even if a
   // request is accepted in the same cycle.
   assign proto_set_s = (r_last_hs_s & (rd_cnt_r == CntZero)) |
                        (b_hs_s & (wr_cnt_r == CntZero));

`ifdef VLSU_AXI_OT_W_GATE_EN
   localparam int              PendW   = $clog2(MaxWPend + 1);
   localparam logic [PendW-1:0] PendMax = PendW'(MaxWPend);

   logic [PendW-1:0] w_pend_r, w_pend_d_s;
   logic             w_open_s, w_last_hs_s;

   // W may only flow once its AW has been accepted.
   assign w_open_s      = (w_pend_r != {PendW{1'b0}});
   assign w_pend_full_s = (w_pend_r == PendMax);
   assign m_w_valid_o   = s_w_valid_i & w_open_s;
   assign s_w_ready_o   = m_w_ready_i & w_open_s;
   assign w_last_hs_s   = s_w_valid_i & m_w_ready_i & w_open_s & s_w_last_i;

   // Next value of the owed-W-last count; gating makes underflow impossible.
   always_comb begin
      w_pend_d_s = w_pend_r;
      case ({aw_hs_s, w_last_hs_s})
         2'b10:   w_pend_d_s = w_pend_r + PendW'(1'b1);
         2'b01:   w_pend_d_s = w_pend_r - PendW'(1'b1);
         default: w_pend_d_s = w_pend_r;
      endcase
   end

   // Owed-W-last count register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         w_pend_r <= {PendW{1'b0}};
      end else begin
         w_pend_r <= w_pend_d_s;
      end
   end
`else
   logic w_last_unused_s;

   assign w_last_unused_s = s_w_last_i;
   assign w_pend_full_s   = 1'b0;
   assign m_w_valid_o     = s_w_valid_i;
   assign s_w_ready_o     = m_w_ready_i;
`endif

   // Next-state for counters and sticky flags; a set beats a same-cycle clear.
   always_comb begin
      rd_cnt_d_s    = next_cnt(rd_cnt_r, ar_hs_s, r_last_hs_s);
      wr_cnt_d_s    = next_cnt(wr_cnt_r, aw_hs_s, b_hs_s);
      resp_err_d_s  = resp_set_s  | (resp_err_r  & ~clr_err_i);
      proto_err_d_s = proto_set_s | (proto_err_r & ~clr_err_i);
   end

   // Tracking state registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_cnt_r    <= CntZero;
         wr_cnt_r    <= CntZero;
         resp_err_r  <= 1'b0;
         proto_err_r <= 1'b0;
      end else begin
         rd_cnt_r    <= rd_cnt_d_s;
         wr_cnt_r    <= wr_cnt_d_s;
         resp_err_r  <= resp_err_d_s;
         proto_err_r <= proto_err_d_s;
      end
   end

   assign rd_ot_o      = rd_cnt_r;
   assign wr_ot_o      = wr_cnt_r;
   assign st_pending_o = (wr_cnt_r != CntZero);
   assign idle_o       = (rd_cnt_r == CntZero) & (wr_cnt_r == CntZero);
   assign resp_err_o   = resp_err_r;
   assign proto_err_o  = proto_err_r;

endmodule

// File: tb/tb_vlsu_axi_ot_tracker.sv
module tb_vlsu_axi_ot_tracker;

   localparam int MaxRdOt  = 8;
   localparam int MaxWrOt  = 8;
   localparam int MaxWPend = 4;
   localparam int CntW     = 4;
`ifdef VLSU_AXI_OT_W_GATE_EN
   localparam bit Gate = 1'b1;
`else
   localparam bit Gate = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_i;
   logic s_aw_valid_i, s_aw_ready_o, m_aw_valid_o, m_aw_ready_i;
   logic s_w_valid_i, s_w_last_i, s_w_ready_o, m_w_valid_o, m_w_ready_i;
   logic m_b_valid_i, m_b_ready_o, s_b_valid_o, s_b_ready_i;
   logic [1:0] m_b_resp_i;
   logic s_ar_valid_i, s_ar_ready_o, m_ar_valid_o, m_ar_ready_i;
   logic m_r_valid_i, m_r_last_i, m_r_ready_o, s_r_valid_o, s_r_ready_i;
   logic [1:0] m_r_resp_i;
   logic clr_err_i;
   logic [CntW-1:0] rd_ot_o, wr_ot_o;
   logic st_pending_o, idle_o, resp_err_o, proto_err_o;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state (plain integers)
   int mdl_rd = 0, mdl_wr = 0, mdl_wp = 0;
   bit mdl_rerr = 1'b0, mdl_perr = 1'b0;

   always #5 clk = ~clk;

   vlsu_axi_ot_tracker #(.MaxRdOt(MaxRdOt), .MaxWrOt(MaxWrOt), .MaxWPend(MaxWPend)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .s_aw_valid_i(s_aw_valid_i), .s_aw_ready_o(s_aw_ready_o),
      .m_aw_valid_o(m_aw_valid_o), .m_aw_ready_i(m_aw_ready_i),
      .s_w_valid_i(s_w_valid_i), .s_w_last_i(s_w_last_i), .s_w_ready_o(s_w_ready_o),
      .m_w_valid_o(m_w_valid_o), .m_w_ready_i(m_w_ready_i),
      .m_b_valid_i(m_b_valid_i), .m_b_resp_i(m_b_resp_i), .m_b_ready_o(m_b_ready_o),
      .s_b_valid_o(s_b_valid_o), .s_b_ready_i(s_b_ready_i),
      .s_ar_valid_i(s_ar_valid_i), .s_ar_ready_o(s_ar_ready_o),
      .m_ar_valid_o(m_ar_valid_o), .m_ar_ready_i(m_ar_ready_i),
      .m_r_valid_i(m_r_valid_i), .m_r_last_i(m_r_last_i), .m_r_resp_i(m_r_resp_i),
      .m_r_ready_o(m_r_ready_o), .s_r_valid_o(s_r_valid_o), .s_r_ready_i(s_r_ready_i),
      .clr_err_i(clr_err_i),
      .rd_ot_o(rd_ot_o), .wr_ot_o(wr_ot_o), .st_pending_o(st_pending_o),
      .idle_o(idle_o), .resp_err_o(resp_err_o), .proto_err_o(proto_err_o)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic all_idle();
      rst_i = 0; clr_err_i = 0;
      s_aw_valid_i = 0; m_aw_ready_i = 0;
      s_w_valid_i = 0; s_w_last_i = 0; m_w_ready_i = 0;
      m_b_valid_i = 0; m_b_resp_i = 2'd0; s_b_ready_i = 0;
      s_ar_valid_i = 0; m_ar_ready_i = 0;
      m_r_valid_i = 0; m_r_last_i = 0; m_r_resp_i = 2'd0; s_r_ready_i = 0;
   endtask

   // One clock: inputs already driven after a negedge. Check outputs against
   // the model, advance the model at the posedge, return at the next negedge.
   task automatic step(input bit do_chk);
      bit rd_full, aw_blk, w_open;
      int ar_hs, aw_hs, r_last, b_hs, w_last;
      bit rset, pset;
      #1;
      rd_full = (mdl_rd == MaxRdOt);
      aw_blk  = (mdl_wr == MaxWrOt) || (Gate && mdl_wp == MaxWPend);
      w_open  = !Gate || (mdl_wp != 0);
      if (do_chk) begin
         check("m_ar_valid", m_ar_valid_o, s_ar_valid_i && !rd_full);
         check("s_ar_ready", s_ar_ready_o, m_ar_ready_i && !rd_full);
         check("m_aw_valid", m_aw_valid_o, s_aw_valid_i && !aw_blk);
         check("s_aw_ready", s_aw_ready_o, m_aw_ready_i && !aw_blk);
         check("m_w_valid", m_w_valid_o, s_w_valid_i && w_open);
         check("s_w_ready", s_w_ready_o, m_w_ready_i && w_open);
         check("s_r_valid", s_r_valid_o, m_r_valid_i);
         check("m_r_ready", m_r_ready_o, s_r_ready_i);
         check("s_b_valid", s_b_valid_o, m_b_valid_i);
         check("m_b_ready", m_b_ready_o, s_b_ready_i);
         check("rd_ot", rd_ot_o, mdl_rd);
         check("wr_ot", wr_ot_o, mdl_wr);
         check("st_pending", st_pending_o, mdl_wr != 0);
         check("idle", idle_o, mdl_rd == 0 && mdl_wr == 0);
         check("resp_err", resp_err_o, mdl_rerr);
         check("proto_err", proto_err_o, mdl_perr);
      end
      ar_hs  = (s_ar_valid_i && m_ar_ready_i && !rd_full) ? 1 : 0;
      aw_hs  = (s_aw_valid_i && m_aw_ready_i && !aw_blk) ? 1 : 0;
      r_last = (m_r_valid_i && s_r_ready_i && m_r_last_i) ? 1 : 0;
      b_hs   = (m_b_valid_i && s_b_ready_i) ? 1 : 0;
      w_last = (s_w_valid_i && m_w_ready_i && w_open && s_w_last_i) ? 1 : 0;
      rset = (m_r_valid_i && s_r_ready_i && m_r_resp_i >= 2) || (b_hs == 1 && m_b_resp_i >= 2);
      pset = (r_last == 1 && mdl_rd == 0) || (b_hs == 1 && mdl_wr == 0);
      @(posedge clk);
      if (rst_i) begin
         mdl_rd = 0; mdl_wr = 0; mdl_wp = 0; mdl_rerr = 0; mdl_perr = 0;
      end else begin
         mdl_rd = mdl_rd + ar_hs - r_last;
         if (mdl_rd < 0) mdl_rd = 0;
         mdl_wr = mdl_wr + aw_hs - b_hs;
         if (mdl_wr < 0) mdl_wr = 0;
         if (Gate) mdl_wp = mdl_wp + aw_hs - w_last;
         mdl_rerr = rset || (mdl_rerr && !clr_err_i);
         mdl_perr = pset || (mdl_perr && !clr_err_i);
      end
      @(negedge clk);
   endtask

   initial begin
      int pv, pc;
      all_idle();
      @(negedge clk);
      rst_i = 1;
      step(0);
      step(1);
      step(1);
      check("rst_rd_ot", rd_ot_o, 0);
      check("rst_idle", idle_o, 1);
      check("rst_errs", {resp_err_o, proto_err_o}, 0);
      all_idle();

      // 9 ARs with no R: 8 accepted, 9th held; one R last lets it in
      s_ar_valid_i = 1; m_ar_ready_i = 1;
      repeat (8) step(1);
      check("rd_cap", rd_ot_o, MaxRdOt);
      #1 check("ar_held", m_ar_valid_o, 0);
      m_r_valid_i = 1; m_r_last_i = 1; s_r_ready_i = 1;
      step(1);
      m_r_valid_i = 0;
      step(1);
      check("rd_refill", rd_ot_o, MaxRdOt);
      s_ar_valid_i = 0; m_r_valid_i = 1;
      repeat (MaxRdOt) step(1);
      check("rd_drained", idle_o, 1);
      all_idle();

      // writes: W last beats flow alongside so gating never limits AW here
      s_w_valid_i = 1; s_w_last_i = 1; m_w_ready_i = 1;
      s_aw_valid_i = 1; m_aw_ready_i = 1;
      repeat (3) step(1);
      m_b_valid_i = 1; s_b_ready_i = 1;
      step(1);
      check("aw_b_same", wr_ot_o, 3);
      check("aw_b_pend", st_pending_o, 1);
      s_aw_valid_i = 0;
      repeat (3) step(1);
      m_b_valid_i = 0; s_aw_valid_i = 1;
      step(1);
      check("wr_seq1", wr_ot_o, 1);
      step(1);
      check("wr_seq2", wr_ot_o, 2);
      s_aw_valid_i = 0; m_b_valid_i = 1;
      step(1);
      check("wr_seq3", wr_ot_o, 1);
      check("wr_seq3_pend", st_pending_o, 1);
      step(1);
      check("wr_seq4", wr_ot_o, 0);
      check("wr_seq4_pend", st_pending_o, 0);
      check("wr_seq4_idle", idle_o, 1);
      all_idle();
      repeat (2) step(1);

      // resp error and clear, then B with nothing outstanding
      m_r_valid_i = 1; m_r_last_i = 1; s_r_ready_i = 1; m_r_resp_i = 2'd2;
      step(1);
      check("resp_err_set", resp_err_o, 1);
      all_idle();
      clr_err_i = 1;
      step(1);
      check("resp_err_clr", resp_err_o, 0);
      clr_err_i = 0;
      m_b_valid_i = 1; s_b_ready_i = 1;
      step(1);
      check("proto_b_unf", proto_err_o, 1);
      check("proto_b_wr", wr_ot_o, 0);
      all_idle();

      // W before any AW
      s_w_valid_i = 1; s_w_last_i = 1; m_w_ready_i = 1;
      #1 check("w_before_aw", m_w_valid_o, Gate ? 0 : 1);
      step(1);
      s_aw_valid_i = 1; m_aw_ready_i = 1;
      step(1);
      s_aw_valid_i = 0;
      #1 check("w_after_aw", m_w_valid_o, 1);
      step(1);
      all_idle();
      m_b_valid_i = 1; s_b_ready_i = 1;
      step(1);
      all_idle();
      clr_err_i = 1;
      step(1);

      // randomized phases: fill-heavy and drain-heavy mixes
      for (int c = 0; c < 4000; c++) begin
         if (c % 200 == 0) begin
            pv = $urandom_range(20, 95);
            pc = $urandom_range(5, 90);
         end
         rst_i        = ($urandom_range(0, 599) == 0);
         clr_err_i    = ($urandom_range(0, 39) == 0);
         s_ar_valid_i = ($urandom_range(0, 99) < pv);
         m_ar_ready_i = ($urandom_range(0, 99) < 70);
         s_aw_valid_i = ($urandom_range(0, 99) < pv);
         m_aw_ready_i = ($urandom_range(0, 99) < 70);
         s_w_valid_i  = ($urandom_range(0, 99) < 60);
         s_w_last_i   = ($urandom_range(0, 99) < 50);
         m_w_ready_i  = ($urandom_range(0, 99) < 70);
         m_r_valid_i  = ($urandom_range(0, 99) < pc);
         m_r_last_i   = ($urandom_range(0, 99) < 60);
         m_r_resp_i   = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(2, 3)) : 2'd0;
         s_r_ready_i  = ($urandom_range(0, 99) < 75);
         m_b_valid_i  = ($urandom_range(0, 99) < pc);
         m_b_resp_i   = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         s_b_ready_i  = ($urandom_range(0, 99) < 75);
         step(1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/vlsu_axi_ot_tracker.md
Name: vlsu_axi_ot_tracker

Overview:
- Sits directly downstream of the vector load/store unit's AXI master port, between it and the memory interconnect.
- Passes the AW, W, B, AR and R channels through with zero added latency.
- Caps outstanding read and write transactions and counts them.
- Provides the "stores in flight" indication and sticky error flags back to the VLSU/dispatcher.
- Payload buses are routed around the block; it sees only handshakes, last bits and resp codes.

Parameters:
- MaxRdOt, 8: maximum outstanding AR bursts (accepted AR without its R last); power of two not required, >=1.
- MaxWrOt, 8: maximum outstanding AW bursts (accepted AW without its B); >=1.
- MaxWPend, 4: maximum AW bursts accepted whose W last has not yet been sent; used only with the gate feature.
- CntW, $clog2(max(MaxRdOt,MaxWrOt)+1): counter width (derived, do not override).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- s_aw_valid_i  in  1  AW valid from VLSU
- s_aw_ready_o  out  1  AW ready to VLSU
- m_aw_valid_o  out  1  AW valid to memory
- m_aw_ready_i  in  1  AW ready from memory
- s_w_valid_i  in  1  W valid from VLSU
- s_w_last_i  in  1  W last from VLSU
- s_w_ready_o  out  1  W ready to VLSU
- m_w_valid_o  out  1  W valid to memory
- m_w_ready_i  in  1  W ready from memory
- m_b_valid_i  in  1  B valid from memory
- m_b_resp_i  in  2  B resp
- m_b_ready_o  out  1  B ready to memory
- s_b_valid_o  out  1  B valid to VLSU
- s_b_ready_i  in  1  B ready from VLSU
- s_ar_valid_i, s_ar_ready_o, m_ar_valid_o, m_ar_ready_i  in/out/out/in  1 each  AR handshake, same pattern as AW
- m_r_valid_i  in  1  R valid
- m_r_last_i  in  1  R last
- m_r_resp_i  in  2  R resp
- m_r_ready_o  out  1  R ready
- s_r_valid_o  out  1  R valid to VLSU
- s_r_ready_i  in  1  R ready from VLSU
- clr_err_i  in  1  clear sticky error flags
- rd_ot_o  out  CntW  outstanding reads
- wr_ot_o  out  CntW  outstanding writes
- st_pending_o  out  1  wr_ot_o != 0
- idle_o  out  1  both counters zero
- resp_err_o  out  1  sticky: any B or R resp of SLVERR (2) or DECERR (3)
- proto_err_o  out  1  sticky: B or R-last handshake with the matching counter at 0

Behaviour:
- Reset (rst_i sampled high at the clock edge):
  - all counters cleared to 0; sticky flags cleared to 0.
  - Resulting outputs: rd_ot_o=0, wr_ot_o=0, st_pending_o=0, idle_o=1, resp_err_o=0, proto_err_o=0.
  - Pass-through valids follow their inputs combinationally, also during reset.
  - Reset mid-burst discards all tracking; no handshake is replayed.
- AR gating:
  - rd_full = (rd_cnt == MaxRdOt), decoded from registered state only.
  - m_ar_valid_o = s_ar_valid_i & !rd_full.
  - s_ar_ready_o = m_ar_ready_i & !rd_full.
  - m_ar_valid_o never depends on m_ar_ready_i.
- AW gating: wr_full = (wr_cnt == MaxWrOt); same pattern as AR.
- R and B: pure pass-through.
  - s_r_valid_o = m_r_valid_i; m_r_ready_o = s_r_ready_i.
  - s_b_valid_o = m_b_valid_i; m_b_ready_o = s_b_ready_i.
- rd_cnt update per cycle:
  - +1 on AR handshake; -1 on R handshake with last=1.
  - Simultaneous +1 and -1: count unchanged.
- wr_cnt update per cycle: +1 on AW handshake; -1 on B handshake. Same simultaneous-event rule.
- Underflow: a decrement with its counter at 0 holds the counter at 0 and sets proto_err_o the next cycle.
- Overflow is impossible by construction of the gating.
- Sticky flags:
  - Set next cycle on the triggering handshake.
  - clr_err_i clears them next cycle; a set in the same cycle as clr_err_i wins.
- Status outputs are registered-state decodes: one cycle after the handshake, zero combinational path from inputs.

Optional Feature:
- Macro: VLSU_AXI_OT_W_GATE_EN.
- Defined:
  - Tracks w_pend: +1 on AW handshake, -1 on W handshake with last.
  - W is blocked while w_pend == 0: m_w_valid_o = s_w_valid_i & (w_pend != 0), and s_w_ready_o likewise.
  - AW is additionally blocked while w_pend == MaxWPend.
  - w_pend resets to 0; simultaneous increment and decrement leaves it unchanged.
  - Effect: the slave never sees W data ahead of its AW.
- Undefined:
  - m_w_valid_o = s_w_valid_i and s_w_ready_o = m_w_ready_i, unconditionally.
  - No w_pend state exists.

Test Plan:
- Issue 9 ARs, MaxRdOt=8, no R → 8 accepted, rd_ot_o=8, 9th held with m_ar_valid_o=0; one R last → 9th accepted next cycle, rd_ot_o stays 8.
- AW handshake and B handshake in the same cycle with wr_cnt=3 → wr_ot_o stays 3, st_pending_o=1.
- 2 AWs, then 2 Bs → wr_ot_o goes 1, 2, 1, 0; st_pending_o falls and idle_o rises 1 cycle after the last B.
- R last with resp=2 → resp_err_o=1 next cycle; clr_err_i pulse → 0 next cycle.
- B with wr_cnt=0 → proto_err_o=1, wr_ot_o stays 0.
- With VLSU_AXI_OT_W_GATE_EN: W valid before any AW → m_w_valid_o=0 until the AW handshake, then the W beat passes the following cycle. Without the macro: the W beat passes immediately.
